spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
- SPI responder (slave) for the far end of the team's SPI master link.
- Mode 0 (CPOL=0, CPHA=0), LSB first, 8-bit frames; multi-byte bursts while ss_n stays low.
- Oversamples the asynchronous sclk/ss_n/mosi pins with the system clk. Exposes a one-deep TX holding buffer, RX byte strobe, a transaction counter and sticky error flags to the register file.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each pin synchronizer (sclk, ss_n, mosi; all identical so they stay aligned); legal range 2..3.
- CNT_W, 8, width of the transaction counter ntx.

Ports:
- clk  in  1  system clock; must be >= 4x sclk frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from the master, asynchronous, idle low.
- ss_n  in  1  slave select, asynchronous, active low.
- mosi  in  1  serial data from the master, asynchronous.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the miso pad; 1 only while selected.
- tx_data  in  8  byte to send.
- tx_wr  in  1  one-cycle write strobe for tx_data into the holding buffer.
- tx_full  out  1  holding buffer occupied.
- rx_data  out  8  last complete received byte; holds until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- ntx  out  CNT_W  count of complete bytes received; wraps.
- clear_ntx  in  1  synchronous clear of ntx.
- clear_flags  in  1  synchronous clear of underrun and abort.
- underrun  out  1  sticky: a byte was started with the holding buffer empty.
- abort  out  1  sticky: ss_n deasserted mid-byte.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_full=0, rx_data=0, rx_valid=0, ntx=0, underrun=0, abort=0, state=WAIT_IDLE, shift registers and bit count = 0. Synchronizer flops reset to the idle pin levels: sclk=0, ss_n=1, mosi=0.
- Edge detect: compare the last synchronizer stage with a one-cycle-delayed copy. The pin-to-action latency is SYNC_STAGES+1 clk cycles.
- States:
  - WAIT_IDLE: reached after reset. Go to IDLE once synced ss_n=1, so a reset during an active select never joins a transfer mid-stream.
  - IDLE: miso_oe=0, miso=0. On a synced ss_n falling edge:
    - load tx_shift from the buffer if tx_full=1 and clear tx_full;
    - otherwise load 0x00 and set underrun;
    - bit_cnt=0; go to SHIFT.
  - SHIFT: miso_oe=1, miso=tx_shift[0].
    - sclk rising: rx_shift <= {mosi_sync, rx_shift[7:1]}; bit_cnt++.
    - 8th rising (bit_cnt 7->0): the next cycle gives rx_data = completed byte, rx_valid=1 for exactly one cycle, ntx++. Then raise an internal byte_done.
    - sclk falling with byte_done=0: tx_shift >>= 1.
    - sclk falling with byte_done=1: reload tx_shift from the buffer (or 0x00 plus underrun, as in IDLE) and clear byte_done. This allows burst transfers.
    - Synced ss_n rising: go to IDLE. If bit_cnt != 0, set abort and discard the partial byte (no rx_valid, ntx unchanged). If bit_cnt = 0, no abort.
- Holding buffer:
  - tx_wr with tx_full=0 latches tx_data and sets tx_full.
  - tx_wr with tx_full=1 is ignored; the buffer keeps its data.
  - tx_wr in the same cycle the buffer is consumed: the new data is latched and tx_full stays 1.
- Counter: ntx wraps 2^CNT_W-1 -> 0. clear_ntx in the same cycle as an increment wins (ntx=0).
- Flags: a set event in the same cycle as clear_flags wins (flag=1).
- sclk edges while synced ss_n=1 are ignored.

Test Plan:
- Reset, tx_wr with tx_data=0xA5, then master sends 0x3C (LSB first, sclk = clk/8) -> miso carries bits 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; ntx=1; tx_full=0; underrun=0.
- Burst with ss_n held low: 0x01 then 0xFF, buffer refilled with 0x55 between bytes -> two rx_valid pulses (0x01, 0xFF); miso sends 0xA5 then 0x55; ntx=2.
- No tx_wr before the frame -> miso all zeros for 8 bits, underrun=1; after clear_flags -> underrun=0.
- ss_n raised after 3 sclk rising edges -> abort=1, no rx_valid, ntx unchanged, miso_oe=0 within SYNC_STAGES+1 cycles.
- 256 complete bytes -> ntx wraps to 0. Then clear_ntx asserted in the same cycle as a byte completion -> ntx=0.
- rst asserted mid-byte with ss_n held low -> all outputs at reset values; no activity until ss_n goes high then low again; the next full byte 0x81 is received correctly.

Source files
------------

// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave_ctrl_if                                               |
// | Brief    : SPI pin bundle plus TX buffer / RX strobe / status register view |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface spi_slave_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             sclk;
    logic             ss_n;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [7:0]       tx_data;
    logic             tx_wr;
    logic             tx_full;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [CNT_W-1:0] ntx;
    logic             clear_ntx;
    logic             clear_flags;
    logic             underrun;
    logic             abort;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_wr, clear_ntx, clear_flags,
        output miso, miso_oe, tx_full, rx_data, rx_valid, ntx, underrun, abort
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_wr, clear_ntx, clear_flags,
        input  miso, miso_oe, tx_full, rx_data, rx_valid, ntx, underrun, abort
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave_ctrl                                                  |
// | Brief    : Oversampled SPI mode-0 responder, LSB first, 8-bit bursts        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spi_slave_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_t;

    localparam logic [1:0] c_settle_max = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_n_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_n_prev_q;
    logic                   w_sclk_s, w_ss_n_s, w_mosi_s;
    logic                   w_sclk_rise, w_sclk_fall, w_ss_fall;

    state_t           state_q, state_d;
    logic [1:0]       settle_q, settle_d;
    logic [7:0]       tx_buf_q, tx_buf_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             tx_full_q, tx_full_d;
    logic             rx_valid_q, rx_valid_d;
    logic             byte_done_q, byte_done_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] ntx_q, ntx_d;
    logic             underrun_q, underrun_d;
    logic             abort_q, abort_d;
    logic             w_load, w_byte_end, w_abort_set;

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_ss_n_s    = ss_n_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;
    assign w_ss_fall   = ~w_ss_n_s & ss_n_prev_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        w_load      = 1'b0;
        w_byte_end  = 1'b0;
        w_abort_set = 1'b0;

        case (state_q)
            // Sync chain restarts at idle levels on reset; wait until it holds the real pin.
            ST_WAIT_IDLE: begin
                if (settle_q != c_settle_max) begin
                    settle_d = settle_q + 2'd1;
                end else if (w_ss_n_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_load      = 1'b1;
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ss_n_s) begin
                    state_d     = ST_IDLE;
                    w_abort_set = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    byte_done_d = 1'b0;
                end else if (w_sclk_rise) begin
                    rx_shift_d = {w_mosi_s, rx_shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = rx_shift_d;
                        rx_valid_d  = 1'b1;
                        w_byte_end  = 1'b1;
                        byte_done_d = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    if (byte_done_q) begin
                        w_load      = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (w_load) begin
            tx_shift_d = tx_full_q ? tx_buf_q : 8'h00;
        end

        // A write landing in the consume cycle refills the buffer immediately.
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q & ~w_load;
        if (bus.tx_wr && (!tx_full_q || w_load)) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end else if (bus.tx_wr) begin
            tx_full_d = 1'b1;
        end

        if (bus.clear_ntx) begin
            ntx_d = '0;
        end else if (w_byte_end) begin
            ntx_d = ntx_q + CNT_W'(1);
        end else begin
            ntx_d = ntx_q;
        end

        underrun_d = (w_load & ~tx_full_q) | (underrun_q & ~bus.clear_flags);
        abort_d    = w_abort_set | (abort_q & ~bus.clear_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b1;
            state_q     <= ST_WAIT_IDLE;
            settle_q    <= 2'd0;
            tx_buf_q    <= 8'h00;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            tx_full_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            ntx_q       <= '0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], bus.ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_q <= w_sclk_s;
            ss_n_prev_q <= w_ss_n_s;
            state_q     <= state_d;
            settle_q    <= settle_d;
            tx_buf_q    <= tx_buf_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            tx_full_q   <= tx_full_d;
            rx_valid_q  <= rx_valid_d;
            byte_done_q <= byte_done_d;
            bit_cnt_q   <= bit_cnt_d;
            ntx_q       <= ntx_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.miso     = (state_q == ST_SHIFT) ? tx_shift_q[0] : 1'b0;
    assign bus.miso_oe  = (state_q == ST_SHIFT);
    assign bus.tx_full  = tx_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.ntx      = ntx_q;
    assign bus.underrun = underrun_q;
    assign bus.abort    = abort_q;
endmodule
`default_nettype wire
